// File: rtl/mdpt_update_queue_pkg.sv
// Shared types for the mdpt update queue.
//   pc38_t                 : 38-bit load PC tag
//   mdp_t                  : 8-bit memory-dependence prediction
//   mdpt_update_src_e      : origin of a queued event (train or violation)
//   mdpt_update_q_entry_t  : one queued update {pc38, mdp, src}
//   MDPT_UPDATE_Q_DEPTH    : default queue depth
package mdpt_update_queue_pkg;

    typedef logic [37:0] pc38_t;
    typedef logic [7:0]  mdp_t;

    localparam int unsigned MDPT_UPDATE_Q_DEPTH = 4;

    typedef enum logic {
        SRC_TRAIN = 1'b0,
        SRC_VIOL  = 1'b1
    } mdpt_update_src_e;

    typedef struct packed {
        pc38_t            pc38;
        mdp_t             mdp;
        mdpt_update_src_e src;
    } mdpt_update_q_entry_t;

endpackage

// File: rtl/mdpt_update_queue_cam.sv
// DEPTH-way pc38 comparator for the mdpt update queue.
// Ports:
//   i_valid   : per-entry participate mask
//   i_tags    : per-entry stored pc38
//   i_query   : incoming pc38
//   o_hit     : per-entry match (one-hot while queued tags are unique)
//   o_any_hit : at least one entry matched
module mdpt_update_cam
    import mdpt_update_queue_pkg::*;
#(
    parameter int unsigned DEPTH = MDPT_UPDATE_Q_DEPTH
) (
    input  logic [DEPTH-1:0] i_valid,
    input  pc38_t            i_tags [DEPTH],
    input  pc38_t            i_query,
    output logic [DEPTH-1:0] o_hit,
    output logic             o_any_hit
);

    always_comb begin
        o_hit = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            o_hit[i] = i_valid[i] && (i_tags[i] == i_query);
        end
    end

    assign o_any_hit = |o_hit;

endmodule

// File: rtl/mdpt_update_queue.sv
// Producer side of the mdpt update port. Buffers violation and commit
// training events in a small FIFO, coalesces events to the same PC and
// emits one registered update per cycle (mdpt never stalls).
// Ports:
//   CLK, nRST                 : clock, async active-low reset
//   viol_valid/ready/pc38/mdp : violation event handshake + payload
//   train_valid/ready/pc38/mdp: commit training handshake + payload
//   update_valid/pc38/mdp     : registered head entry driven to mdpt
module mdpt_update_queue
    import mdpt_update_queue_pkg::*;
#(
    parameter int unsigned DEPTH = MDPT_UPDATE_Q_DEPTH
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  viol_valid,
    output logic  viol_ready,
    input  pc38_t viol_pc38,
    input  mdp_t  viol_mdp,
    input  logic  train_valid,
    output logic  train_ready,
    input  pc38_t train_pc38,
    input  mdp_t  train_mdp,
    output logic  update_valid,
    output pc38_t update_pc38,
    output mdp_t  update_mdp
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [CW-1:0] ptr_t;
    typedef logic [IW-1:0] idx_t;

    // Pointer advance modulo DEPTH (DEPTH need not be a power of two).
    function automatic ptr_t ptr_inc(input ptr_t p, input ptr_t n);
        logic [CW:0] s;
        s = {1'b0, p} + {1'b0, n};
        if (s >= (CW+1)'(DEPTH)) begin
            s = s - (CW+1)'(DEPTH);
        end
        return s[CW-1:0];
    endfunction

    mdpt_update_q_entry_t r_entries [DEPTH];
    ptr_t                 r_head;
    ptr_t                 r_tail;
    ptr_t                 r_count;
    logic                 r_upd_valid;
    pc38_t                r_upd_pc38;
    mdp_t                 r_upd_mdp;

    mdpt_update_q_entry_t w_entries_nxt [DEPTH];
    pc38_t                w_tags [DEPTH];
    logic [DEPTH-1:0]     w_live;
    logic [DEPTH-1:0]     w_viol_hit;
    logic [DEPTH-1:0]     w_train_hit;
    logic                 w_viol_any;
    logic                 w_train_any;
    logic                 w_viol_fire;
    logic                 w_train_fire;
    logic                 w_pop;
    ptr_t                 w_n_alloc;
    ptr_t                 w_head_nxt;
    ptr_t                 w_tail_nxt;
    ptr_t                 w_count_nxt;

    // Readiness is taken from the pre-pop count; the last slot is kept
    // for violations only.
    assign viol_ready   = (r_count <= ptr_t'(DEPTH - 1));
    assign train_ready  = (r_count <= ptr_t'(DEPTH - 2));
    assign w_viol_fire  = viol_valid && viol_ready;
    assign w_train_fire = train_valid && train_ready;
    assign w_pop        = (r_count != '0);

    // Live entries for coalescing: every queued entry except the head,
    // which is always leaving this cycle when the queue is non-empty.
    always_comb begin
        int unsigned off;
        w_live = '0;
        off    = 0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off       = (i >= 32'(r_head)) ? (i - 32'(r_head))
                                           : (i + DEPTH - 32'(r_head));
            w_live[i] = (off != 0) && (off < 32'(r_count));
            w_tags[i] = r_entries[i].pc38;
        end
    end

    mdpt_update_cam #(.DEPTH(DEPTH)) u_viol_cam (
        .i_valid   (w_live),
        .i_tags    (w_tags),
        .i_query   (viol_pc38),
        .o_hit     (w_viol_hit),
        .o_any_hit (w_viol_any)
    );

    mdpt_update_cam #(.DEPTH(DEPTH)) u_train_cam (
        .i_valid   (w_live),
        .i_tags    (w_tags),
        .i_query   (train_pc38),
        .o_hit     (w_train_hit),
        .o_any_hit (w_train_any)
    );

    // Violation is applied first; a training event to the same PC in the
    // same cycle is dropped. A training hit only refreshes entries that
    // were themselves queued by training.
    always_comb begin
        w_entries_nxt = r_entries;
        w_n_alloc     = '0;
        if (w_viol_fire) begin
            if (w_viol_any) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (w_viol_hit[i]) begin
                        w_entries_nxt[i].mdp = viol_mdp;
                        w_entries_nxt[i].src = SRC_VIOL;
                    end
                end
            end else begin
                w_entries_nxt[idx_t'(r_tail)] =
                    '{pc38: viol_pc38, mdp: viol_mdp, src: SRC_VIOL};
                w_n_alloc = ptr_t'(1);
            end
        end
        if (w_train_fire && !(w_viol_fire && (train_pc38 == viol_pc38))) begin
            if (w_train_any) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (w_train_hit[i] && (r_entries[i].src == SRC_TRAIN)) begin
                        w_entries_nxt[i].mdp = train_mdp;
                    end
                end
            end else begin
                w_entries_nxt[idx_t'(ptr_inc(r_tail, w_n_alloc))] =
                    '{pc38: train_pc38, mdp: train_mdp, src: SRC_TRAIN};
                w_n_alloc = w_n_alloc + ptr_t'(1);
            end
        end
    end

    assign w_head_nxt  = w_pop ? ptr_inc(r_head, ptr_t'(1)) : r_head;
    assign w_tail_nxt  = ptr_inc(r_tail, w_n_alloc);
    assign w_count_nxt = r_count + w_n_alloc - ptr_t'(w_pop);

    // The output register is loaded from the next-state head, so it
    // reflects any coalescing that lands on the new head this cycle.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_upd_valid <= 1'b0;
            r_upd_pc38  <= '0;
            r_upd_mdp   <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_entries[i] <= w_entries_nxt[i];
            end
            r_head      <= w_head_nxt;
            r_tail      <= w_tail_nxt;
            r_count     <= w_count_nxt;
            r_upd_valid <= (w_count_nxt != '0);
            if (w_count_nxt != '0) begin
                r_upd_pc38 <= w_entries_nxt[idx_t'(w_head_nxt)].pc38;
                r_upd_mdp  <= w_entries_nxt[idx_t'(w_head_nxt)].mdp;
            end
        end
    end

    assign update_valid = r_upd_valid;
    assign update_pc38  = r_upd_pc38;
    assign update_mdp   = r_upd_mdp;

    a_no_overflow: assert property (@(posedge CLK) disable iff (!nRST)
        (32'(r_count) + 32'(w_n_alloc)) <= DEPTH + 32'(w_pop) && r_count <= ptr_t'(DEPTH));

endmodule

// File: tb/tb_mdpt_update_queue.sv
module tb_mdpt_update_queue;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        viol_valid = 1'b0;
    logic        viol_ready;
    logic [37:0] viol_pc38 = '0;
    logic [7:0]  viol_mdp = '0;
    logic        train_valid = 1'b0;
    logic        train_ready;
    logic [37:0] train_pc38 = '0;
    logic [7:0]  train_mdp = '0;
    logic        update_valid;
    logic [37:0] update_pc38;
    logic [7:0]  update_mdp;

    mdpt_update_queue #(.DEPTH(DEPTH)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .viol_valid   (viol_valid),
        .viol_ready   (viol_ready),
        .viol_pc38    (viol_pc38),
        .viol_mdp     (viol_mdp),
        .train_valid  (train_valid),
        .train_ready  (train_ready),
        .train_pc38   (train_pc38),
        .train_mdp    (train_mdp),
        .update_valid (update_valid),
        .update_pc38  (update_pc38),
        .update_mdp   (update_mdp)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: an ordered list of pending events; the front is what
    // mdpt sees this cycle and leaves at the next edge.
    typedef struct {
        logic [37:0] pc;
        logic [7:0]  mdp;
        bit          viol;
    } ev_t;

    ev_t         q[$];
    logic        exp_valid = 1'b0;
    logic [37:0] exp_pc = '0;
    logic [7:0]  exp_mdp = '0;

    function automatic int find_pc(input logic [37:0] pc);
        foreach (q[k]) if (q[k].pc == pc) return k;
        return -1;
    endfunction

    task automatic model_reset();
        q.delete();
        exp_valid = 1'b0;
        exp_pc    = '0;
        exp_mdp   = '0;
    endtask

    task automatic step(input bit vv, input logic [37:0] vpc, input logic [7:0] vmdp,
                        input bit tv, input logic [37:0] tpc, input logic [7:0] tmdp);
        bit vf;
        bit tf;
        int idx;
        viol_valid  = vv;
        viol_pc38   = vpc;
        viol_mdp    = vmdp;
        train_valid = tv;
        train_pc38  = tpc;
        train_mdp   = tmdp;
        check("viol_ready", viol_ready, q.size() <= DEPTH - 1);
        check("train_ready", train_ready, q.size() <= DEPTH - 2);
        vf = vv && (q.size() <= DEPTH - 1);
        tf = tv && (q.size() <= DEPTH - 2);
        @(posedge CLK);
        if (q.size() > 0) void'(q.pop_front());
        if (vf) begin
            idx = find_pc(vpc);
            if (idx >= 0) begin
                q[idx].mdp  = vmdp;
                q[idx].viol = 1'b1;
            end else begin
                q.push_back('{pc: vpc, mdp: vmdp, viol: 1'b1});
            end
        end
        if (tf && !(vf && (tpc == vpc))) begin
            idx = find_pc(tpc);
            if (idx >= 0) begin
                if (!q[idx].viol) q[idx].mdp = tmdp;
            end else begin
                q.push_back('{pc: tpc, mdp: tmdp, viol: 1'b0});
            end
        end
        exp_valid = (q.size() != 0);
        if (exp_valid) begin
            exp_pc  = q[0].pc;
            exp_mdp = q[0].mdp;
        end
        #1;
        check("update_valid", update_valid, exp_valid);
        check("update_pc38", update_pc38, exp_pc);
        check("update_mdp", update_mdp, exp_mdp);
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        model_reset();
        #12;
        check("rst_valid", update_valid, 1'b0);
        check("rst_pc", update_pc38, 38'h0);
        check("rst_mdp", update_mdp, 8'h0);
        check("rst_viol_ready", viol_ready, 1'b1);
        check("rst_train_ready", train_ready, 1'b1);
        @(negedge CLK);
        nRST = 1'b1;

        // Single violation: one cycle of update, then empty with held payload.
        step(1'b1, 38'h10, 8'h05, 1'b0, '0, '0);
        check("single_valid", update_valid, 1'b1);
        check("single_pc", update_pc38, 38'h10);
        check("single_mdp", update_mdp, 8'h05);
        idle();
        check("single_gone", update_valid, 1'b0);
        check("single_hold_pc", update_pc38, 38'h10);

        // Same-cycle violation and training with different PCs.
        step(1'b1, 38'h20, 8'h21, 1'b1, 38'h30, 8'h31);
        check("pair_first", update_pc38, 38'h20);
        idle();
        check("pair_second", update_pc38, 38'h30);
        check("pair_second_v", update_valid, 1'b1);
        idle();
        check("pair_empty", update_valid, 1'b0);

        // Violation coalesces onto a queued training entry.
        step(1'b1, 38'h3A, 8'h02, 1'b1, 38'h40, 8'h01);
        step(1'b1, 38'h40, 8'h07, 1'b0, '0, '0);
        check("coal_pc", update_pc38, 38'h40);
        check("coal_mdp", update_mdp, 8'h07);
        idle();
        check("coal_single", update_valid, 1'b0);

        // Training after violation to the same PC is acked but dropped.
        step(1'b1, 38'h61, 8'h03, 1'b1, 38'h62, 8'h04);
        step(1'b1, 38'h50, 8'h09, 1'b0, '0, '0);
        step(1'b0, '0, '0, 1'b1, 38'h50, 8'h02);
        check("tav_pc", update_pc38, 38'h50);
        check("tav_mdp", update_mdp, 8'h09);
        idle();
        check("tav_empty", update_valid, 1'b0);

        // Same PC on both sources in one cycle: training dropped.
        step(1'b1, 38'h50, 8'h0A, 1'b1, 38'h50, 8'h0B);
        check("same_mdp", update_mdp, 8'h0A);
        idle();
        check("same_single", update_valid, 1'b0);

        // Both sources held valid with distinct PCs; readies back-pressure.
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 38'h100 + 38'(2 * k), 8'(k), 1'b1, 38'h101 + 38'(2 * k), 8'(8'h80 + k));
        end
        for (int k = 0; k < 8; k++) idle();
        check("hold_drained", update_valid, 1'b0);

        // Asynchronous reset with three entries queued.
        step(1'b1, 38'h70, 8'h01, 1'b1, 38'h71, 8'h02);
        step(1'b1, 38'h72, 8'h03, 1'b1, 38'h73, 8'h04);
        viol_valid  = 1'b0;
        train_valid = 1'b0;
        #2;
        nRST = 1'b0;
        #1;
        check("arst_valid", update_valid, 1'b0);
        check("arst_pc", update_pc38, 38'h0);
        check("arst_viol_ready", viol_ready, 1'b1);
        check("arst_train_ready", train_ready, 1'b1);
        model_reset();
        @(negedge CLK);
        nRST = 1'b1;
        for (int k = 0; k < 4; k++) idle();

        // Randomised traffic over a small PC pool to force coalescing.
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 1)), 38'h200 + 38'($urandom_range(0, 5)), 8'($urandom),
                 1'($urandom_range(0, 1)), 38'h200 + 38'($urandom_range(0, 5)), 8'($urandom));
        end
        for (int k = 0; k < 6; k++) idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
